prbs_checker: RTL and testbench

//  Receive-side checker for the pseudo-random bit streams our LFSR generators produce.
//  It compares each sampled bit with the bit predicted from the stream's own history.
//  It reports lock, per-bit error pulses and a saturating error count.
//  Use: PLL dither/PRBS bring-up and on-chip BIST of generator outputs.

---
 rtl/prnd_pkg.sv | 12 +
 rtl/lfsr_predictor.sv | 33 +++
 rtl/prbs_checker.sv | 148 ++++++++++++++
 tb/tb_prbs_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prnd_pkg.sv
// rtl/prnd_pkg.sv - shared types and constants for the PRBS checker
package prnd_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [15:0] PRND_MASK_16 = 16'hB400;

endpackage

// File: rtl/lfsr_predictor.sv
// rtl/lfsr_predictor.sv - history shift register and next-bit prediction for prbs_checker
module lfsr_predictor
  import prnd_pkg::*;
#(
  parameter int                  NUM_BITS = 16,
  parameter logic [NUM_BITS-1:0] MASK     = NUM_BITS'(PRND_MASK_16)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                advance,
  input  logic                use_pred,
  input  logic                bit_in,
  output logic                mismatch,
  output logic [NUM_BITS-1:0] hist_next
);

  logic [NUM_BITS-1:0] hist;
  logic                pred;

  // hist[0] is the most recent sample, so a left shift ages every entry by one
  assign pred      = ^(hist & MASK);
  assign mismatch  = bit_in ^ pred;
  assign hist_next = {hist[NUM_BITS-2:0], use_pred ? pred : bit_in};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else if (advance) begin
      hist <= hist_next;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS receive checker: lock FSM, loss-of-lock window and error counter
module prbs_checker
  import prnd_pkg::*;
#(
  parameter int                       NUM_LFSR_BITS  = 16,
  parameter logic [NUM_LFSR_BITS-1:0] FEEDBACK_MASK  = NUM_LFSR_BITS'(PRND_MASK_16),
  parameter int                       LOCK_COUNT     = 32,
  parameter int                       LOSS_WINDOW    = 64,
  parameter int                       LOSS_THRESHOLD = 8,
  parameter int                       ERR_CNT_BITS   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    dataValid,
  input  logic                    dataIn,
  input  logic                    clearCount,
  output logic                    locked,
  output logic                    errorPulse,
  output logic                    lossOfLock,
  output logic [ERR_CNT_BITS-1:0] errorCount
);

  localparam int SW = $clog2(NUM_LFSR_BITS + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESHOLD + 1);

  localparam logic [SW-1:0] SAMP_END  = SW'(NUM_LFSR_BITS);
  localparam logic [MW-1:0] MATCH_END = MW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_END   = WW'(LOSS_WINDOW);
  localparam logic [EW-1:0] ERR_END   = EW'(LOSS_THRESHOLD);

  chk_state_t state, state_nxt;
  logic [SW-1:0] samp_cnt, samp_nxt, samp_inc;
  logic [MW-1:0] match_cnt, match_nxt, match_inc;
  logic [WW-1:0] win_cnt, win_nxt, win_inc;
  logic [EW-1:0] win_err, werr_nxt, werr_inc;

  logic                     sample;
  logic                     mismatch;
  logic [NUM_LFSR_BITS-1:0] hist_next;
  logic                     pulse_nxt;
  logic                     loss_nxt;

  assign sample    = enable & dataValid;
  assign samp_inc  = samp_cnt + 1'b1;
  assign match_inc = match_cnt + 1'b1;
  assign win_inc   = win_cnt + 1'b1;
  assign werr_inc  = win_err + EW'(mismatch);

  lfsr_predictor #(
    .NUM_BITS(NUM_LFSR_BITS),
    .MASK    (FEEDBACK_MASK)
  ) u_pred (
    .clock    (clock),
    .reset    (reset),
    .advance  (sample),
    .use_pred (state == LOCKED),
    .bit_in   (dataIn),
    .mismatch (mismatch),
    .hist_next(hist_next)
  );

  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    match_nxt = match_cnt;
    win_nxt   = win_cnt;
    werr_nxt  = win_err;
    pulse_nxt = 1'b0;
    loss_nxt  = 1'b0;
    if (sample) begin
      case (state)
        SEARCH: begin
          if (samp_inc == SAMP_END) begin
            state_nxt = VERIFY;
            samp_nxt  = '0;
            match_nxt = '0;
          end else begin
            samp_nxt = samp_inc;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            match_nxt = '0;
          end else if (match_inc == MATCH_END) begin
            // an all-zero history satisfies any linear recurrence, so it never locks
            match_nxt = '0;
            if (hist_next != '0) begin
              state_nxt = LOCKED;
              win_nxt   = '0;
              werr_nxt  = '0;
            end
          end else begin
            match_nxt = match_inc;
          end
        end
        LOCKED: begin
          pulse_nxt = mismatch;
          if (werr_inc == ERR_END) begin
            state_nxt = SEARCH;
            loss_nxt  = 1'b1;
            samp_nxt  = '0;
            win_nxt   = '0;
            werr_nxt  = '0;
          end else if (win_inc == WIN_END) begin
            win_nxt  = '0;
            werr_nxt = '0;
          end else begin
            win_nxt  = win_inc;
            werr_nxt = werr_inc;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      samp_cnt   <= '0;
      match_cnt  <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
      locked     <= 1'b0;
      errorPulse <= 1'b0;
      lossOfLock <= 1'b0;
      errorCount <= '0;
    end else begin
      state      <= state_nxt;
      samp_cnt   <= samp_nxt;
      match_cnt  <= match_nxt;
      win_cnt    <= win_nxt;
      win_err    <= werr_nxt;
      locked     <= (state_nxt == LOCKED);
      errorPulse <= pulse_nxt;
      lossOfLock <= loss_nxt;
      if (enable && clearCount) begin
        errorCount <= '0;
      end else if (pulse_nxt && (errorCount != '1)) begin
        errorCount <= errorCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker
module tb_prbs_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        dataValid = 1'b0;
  logic        dataIn = 1'b0;
  logic        clearCount = 1'b0;
  logic        locked, errorPulse, lossOfLock;
  logic [15:0] errorCount;
  logic        locked2, pulse2, loss2;
  logic [1:0]  count2;

  always #5 clock = ~clock;

  prbs_checker dut (
    .clock(clock), .reset(reset), .enable(enable), .dataValid(dataValid),
    .dataIn(dataIn), .clearCount(clearCount), .locked(locked),
    .errorPulse(errorPulse), .lossOfLock(lossOfLock), .errorCount(errorCount)
  );

  prbs_checker #(.ERR_CNT_BITS(2)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .dataValid(dataValid),
    .dataIn(dataIn), .clearCount(clearCount), .locked(locked2),
    .errorPulse(pulse2), .lossOfLock(loss2), .errorCount(count2)
  );

  int tests = 0;
  int fails = 0;
  int n_loss, n_err;

  localparam int M_CLEAN = 0, M_FLIP = 1, M_ZERO = 2, M_TOGGLE = 3, M_ENLOW = 4, M_RAND = 5;

  typedef struct {
    string name;
    bit    rst;
    int    n;
    int    mode;
    bit    clr_first;
    int    exp_lock;
    int    exp_cnt;
    int    exp_cnt2;
    int    exp_loss;
    int    exp_err;
  } phase_t;

  phase_t ph[$];

  // reference model: history as a list of past bits, newest first
  bit hq[$];
  int m_mode;  // 0 hunting, 1 confirming, 2 locked
  int m_fill, m_match, m_win, m_werr, m_cnt, m_cnt2;
  bit m_pulse, m_loss;

  // stream generator: b[n] = b[n-16]^b[n-14]^b[n-13]^b[n-11], first 16 bits from the seed
  bit          gq[$];
  int          g_idx;
  logic [15:0] seed = 16'hACE1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic g_reset();
    gq.delete();
    g_idx = 0;
  endtask

  function automatic bit gen_next();
    bit b;
    if (g_idx < 16) b = seed[g_idx];
    else b = gq[15] ^ gq[13] ^ gq[12] ^ gq[10];
    gq.push_front(b);
    if (gq.size() > 16) void'(gq.pop_back());
    g_idx++;
    return b;
  endfunction

  task automatic model_reset();
    hq.delete();
    for (int j = 0; j < 16; j++) hq.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_cnt = 0; m_cnt2 = 0; m_pulse = 0; m_loss = 0;
  endtask

  task automatic model_step(input bit en, input bit dv, input bit din, input bit clr);
    bit p, mis, any;
    m_pulse = 0;
    m_loss  = 0;
    if (en && dv) begin
      p   = hq[10] ^ hq[12] ^ hq[13] ^ hq[15];
      mis = din ^ p;
      if (m_mode == 2) begin
        hq.push_front(p);
        void'(hq.pop_back());
        m_win++;
        if (mis) begin
          m_pulse = 1;
          m_werr++;
          if (!clr) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
        end
        if (m_werr == 8) begin
          m_mode = 0; m_fill = 0; m_loss = 1;
        end else if (m_win == 64) begin
          m_win = 0; m_werr = 0;
        end
      end else begin
        hq.push_front(din);
        void'(hq.pop_back());
        if (m_mode == 0) begin
          m_fill++;
          if (m_fill == 16) begin m_mode = 1; m_match = 0; end
        end else if (mis) begin
          m_match = 0;
        end else begin
          m_match++;
          if (m_match == 32) begin
            m_match = 0;
            any = 0;
            foreach (hq[j]) any |= hq[j];
            if (any) begin m_mode = 2; m_win = 0; m_werr = 0; end
          end
        end
      end
    end
    if (en && clr) begin m_cnt = 0; m_cnt2 = 0; end
  endtask

  task automatic step(input bit en, input bit dv, input bit din, input bit clr);
    bit ml;
    enable = en; dataValid = dv; dataIn = din; clearCount = clr;
    @(posedge clock);
    model_step(en, dv, din, clr);
    @(negedge clock);
    n_loss += int'(lossOfLock);
    n_err  += int'(errorPulse);
    ml = (m_mode == 2);
    check("model_cycle",
          {locked, errorPulse, lossOfLock, errorCount, locked2, pulse2, loss2, count2},
          {ml, m_pulse, m_loss, 16'(m_cnt), ml, m_pulse, m_loss, 2'(m_cnt2)});
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 0; dataValid = 0; dataIn = 0; clearCount = 0;
    #2;
    model_reset();
    g_reset();
    check("reset_outputs",
          {locked, errorPulse, lossOfLock, errorCount, locked2, pulse2, loss2, count2}, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic add(input string nm, input bit rst, input int n, input int mode, input bit clr,
                     input int el, input int ec, input int ec2, input int elo, input int ee);
    phase_t p;
    p.name = nm; p.rst = rst; p.n = n; p.mode = mode; p.clr_first = clr;
    p.exp_lock = el; p.exp_cnt = ec; p.exp_cnt2 = ec2; p.exp_loss = elo; p.exp_err = ee;
    ph.push_back(p);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //  name              rst  n     mode      clr lock cnt cnt2 loss err
    add("reset",           1,  0,    M_CLEAN,  0,  0,   0,  0,   -1,  -1);
    add("search_47",       0,  47,   M_CLEAN,  0,  0,   0,  0,   0,   0);
    add("lock_48",         0,  1,    M_CLEAN,  0,  1,   0,  0,   0,   0);
    add("clean_10000",     0,  9952, M_CLEAN,  0,  1,   0,  0,   0,   0);
    add("flip_one",        0,  1,    M_FLIP,   0,  1,   1,  1,   0,   1);
    add("clean_clear",     0,  95,   M_CLEAN,  1,  1,   0,  0,   0,   0);
    add("flip_eight",      0,  8,    M_FLIP,   0,  0,   8,  3,   1,   8);
    add("relock_47",       0,  47,   M_CLEAN,  0,  0,   8,  3,   0,   0);
    add("relock_48",       0,  1,    M_CLEAN,  0,  1,   8,  3,   0,   0);
    add("zeros_500",       1,  500,  M_ZERO,   0,  0,   0,  0,   0,   0);
    add("toggle_47",       1,  94,   M_TOGGLE, 0,  0,   0,  0,   0,   0);
    add("toggle_48",       0,  2,    M_TOGGLE, 0,  1,   0,  0,   0,   0);
    add("flip_before_off", 0,  1,    M_FLIP,   0,  1,   1,  1,   0,   1);
    add("enable_low_20",   0,  20,   M_ENLOW,  0,  1,   1,  1,   0,   0);
    add("resume_clear",    0,  10,   M_CLEAN,  1,  1,   0,  0,   0,   0);
    add("flip_two",        0,  2,    M_FLIP,   0,  1,   2,  2,   0,   2);
    add("flip_three_sat",  0,  3,    M_FLIP,   0,  1,   5,  3,   0,   3);
    add("clear_with_err",  0,  1,    M_FLIP,   1,  1,   0,  0,   0,   1);
    add("random",          0,  3000, M_RAND,   0,  -1,  -1, -1,  -1,  -1);

    foreach (ph[k]) begin
      if (ph[k].rst) do_reset();
      n_loss = 0;
      n_err  = 0;
      for (int i = 0; i < ph[k].n; i++) begin
        bit en, dv, din, clr, flip;
        en = 1; dv = 1; flip = 0;
        clr = ph[k].clr_first && (i == 0);
        case (ph[k].mode)
          M_FLIP:   flip = 1;
          M_TOGGLE: dv = (i % 2 == 0);
          M_ENLOW: begin
            en  = 0;
            dv  = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
          end
          M_RAND: begin
            en   = ($urandom_range(0, 7) != 0);
            dv   = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 63) == 0);
            flip = ($urandom_range(0, 31) == 0);
          end
          default: ;
        endcase
        if (ph[k].mode == M_ZERO) din = 0;
        else if (en && dv) din = gen_next() ^ flip;
        else din = 1'($urandom_range(0, 1));
        step(en, dv, din, clr);
      end
      if (ph[k].exp_lock >= 0) check({ph[k].name, ".locked"}, locked, ph[k].exp_lock);
      if (ph[k].exp_cnt >= 0) check({ph[k].name, ".errorCount"}, errorCount, ph[k].exp_cnt);
      if (ph[k].exp_cnt2 >= 0) check({ph[k].name, ".satCount"}, count2, ph[k].exp_cnt2);
      if (ph[k].exp_loss >= 0) check({ph[k].name, ".lossPulses"}, n_loss, ph[k].exp_loss);
      if (ph[k].exp_err >= 0) check({ph[k].name, ".errPulses"}, n_err, ph[k].exp_err);
    end

    // reset asserted mid-stream aborts straight to reset values
    step(1, 1, gen_next(), 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
